// File: rtl/q6_fsm_pkg.sv
// Q6 six-state machine: state codes, one-hot bit indices and shared transition/output functions.
package q6_fsm_pkg;

  typedef enum logic [2:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } q6_state_e;

  // One-hot bit index equals the binary code.
  localparam int OH_A = 0;
  localparam int OH_B = 1;
  localparam int OH_C = 2;
  localparam int OH_D = 3;
  localparam int OH_E = 4;
  localparam int OH_F = 5;
  localparam int OH_W = 6;

  function automatic logic [2:0] q6_next(input logic [2:0] s, input logic w);
    case (s)
      ST_A:    q6_next = w ? ST_A : ST_B;
      ST_B:    q6_next = w ? ST_D : ST_C;
      ST_C:    q6_next = w ? ST_D : ST_E;
      ST_D:    q6_next = w ? ST_A : ST_F;
      ST_E:    q6_next = w ? ST_D : ST_E;
      ST_F:    q6_next = w ? ST_D : ST_C;
      default: q6_next = ST_A;
    endcase
  endfunction

  function automatic logic q6_z(input logic [2:0] s);
    return (s == ST_E) || (s == ST_F);
  endfunction

endpackage

// File: rtl/q6_fsm_lane.sv
// One Q6 lane: state register (binary or one-hot), registered z, next-state bit-1 view,
// and a saturating counter of entries into F.
module q6_fsm_lane
  import q6_fsm_pkg::*;
#(
  parameter int ONEHOT = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             w,
  input  logic             clr_cnt,
  output logic [2:0]       state,
  output logic             z,
  output logic             y2_next,
  output logic [CNT_W-1:0] f_count,
  output logic             f_sat
);

  logic [2:0]       w_cur;
  logic             w_legal;
  logic [2:0]       w_nxt;
  logic             w_inc;
  logic [CNT_W-1:0] w_cnt_p1;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;

  generate
    if (ONEHOT != 0) begin : g_oh
      logic [OH_W-1:0] r_oh;

      always_comb begin
        w_legal = 1'b1;
        w_cur   = ST_A;
        case (r_oh)
          6'b000001: w_cur = ST_A;
          6'b000010: w_cur = ST_B;
          6'b000100: w_cur = ST_C;
          6'b001000: w_cur = ST_D;
          6'b010000: w_cur = ST_E;
          6'b100000: w_cur = ST_F;
          default:   w_legal = 1'b0;
        endcase
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_oh <= OH_W'(1) << OH_A;
          r_z  <= 1'b0;
        end else if (en) begin
          r_oh <= OH_W'(1) << w_nxt;
          r_z  <= q6_z(w_nxt);
        end
      end
    end else begin : g_bin
      q6_state_e r_bin;

      always_comb begin
        w_legal = (r_bin <= ST_F);
        w_cur   = w_legal ? r_bin : ST_A;
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_bin <= ST_A;
          r_z   <= 1'b0;
        end else if (en) begin
          r_bin <= q6_state_e'(w_nxt);
          r_z   <= q6_z(w_nxt);
        end
      end
    end
  endgenerate

  // Illegal patterns recover to A, which also makes their y2_next view 0.
  assign w_nxt    = w_legal ? q6_next(w_cur, w) : ST_A;
  assign w_inc    = en && (w_nxt == ST_F) && (w_cur != ST_F);
  assign w_cnt_p1 = r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (clr_cnt) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_inc && !r_sat) begin
      r_cnt <= w_cnt_p1;
      r_sat <= &w_cnt_p1;
    end
  end

  assign state   = w_cur;
  assign z       = r_z & w_legal;
  assign y2_next = w_nxt[1];
  assign f_count = r_cnt;
  assign f_sat   = r_sat;

endmodule

// File: rtl/q6_fsm_array.sv
// CHANNELS independent Q6 lanes sharing one clock, reset and counter clear.
module q6_fsm_array
  import q6_fsm_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ONEHOT   = 0,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       w,
  input  logic                      clr_cnt,
  output logic [3*CHANNELS-1:0]     state,
  output logic [CHANNELS-1:0]       z,
  output logic [CHANNELS-1:0]       y2_next,
  output logic [CNT_W*CHANNELS-1:0] f_count,
  output logic [CHANNELS-1:0]       f_sat
);

  genvar i;
  generate
    for (i = 0; i < CHANNELS; i++) begin : g_lane
      q6_fsm_lane #(
        .ONEHOT (ONEHOT),
        .CNT_W  (CNT_W)
      ) u_lane (
        .clk     (clk),
        .resetn  (resetn),
        .en      (en[i]),
        .w       (w[i]),
        .clr_cnt (clr_cnt),
        .state   (state[3*i +: 3]),
        .z       (z[i]),
        .y2_next (y2_next[i]),
        .f_count (f_count[CNT_W*i +: CNT_W]),
        .f_sat   (f_sat[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_q6_fsm_array.sv
// Directed and random checks of q6_fsm_array in binary, one-hot and narrow-counter builds.
module tb_q6_fsm_array;
  import q6_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  en = '0;
  logic [3:0]  w = '0;
  logic        clr_cnt = 1'b0;

  logic [11:0] st_b, st_o, st_s;
  logic [3:0]  z_b, z_o, z_s, y2_b, y2_o, y2_s, fs_b, fs_o, fs_s;
  logic [31:0] fc_b, fc_o;
  logic [7:0]  fc_s;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  q6_fsm_array #(.CHANNELS(4), .ONEHOT(0), .CNT_W(8)) u_bin (
    .clk(clk), .resetn(resetn), .en(en), .w(w), .clr_cnt(clr_cnt),
    .state(st_b), .z(z_b), .y2_next(y2_b), .f_count(fc_b), .f_sat(fs_b));

  q6_fsm_array #(.CHANNELS(4), .ONEHOT(1), .CNT_W(8)) u_oh (
    .clk(clk), .resetn(resetn), .en(en), .w(w), .clr_cnt(clr_cnt),
    .state(st_o), .z(z_o), .y2_next(y2_o), .f_count(fc_o), .f_sat(fs_o));

  q6_fsm_array #(.CHANNELS(4), .ONEHOT(0), .CNT_W(2)) u_sat (
    .clk(clk), .resetn(resetn), .en(en), .w(w), .clr_cnt(clr_cnt),
    .state(st_s), .z(z_s), .y2_next(y2_s), .f_count(fc_s), .f_sat(fs_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn  = 1'b0;
    en      = '0;
    w       = '0;
    clr_cnt = 1'b0;
    @(negedge clk);
    resetn  = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    en = 4'hF;
    w = 4'hF;
    clr_cnt = 1'b1;
    #12;
    checks++; if (st_b !== 12'h000) begin errs++; $display("FAIL reset_state_bin got %h want 000", st_b); end
    checks++; if (st_o !== 12'h000) begin errs++; $display("FAIL reset_state_oh got %h want 000", st_o); end
    checks++; if (z_b !== 4'h0 || z_o !== 4'h0) begin errs++; $display("FAIL reset_z got %b/%b want 0000", z_b, z_o); end
    checks++; if (fc_b !== 32'h0 || fc_o !== 32'h0 || fc_s !== 8'h0) begin errs++; $display("FAIL reset_fcount got %h/%h/%h want 0", fc_b, fc_o, fc_s); end
    checks++; if (fs_b !== 4'h0 || fs_s !== 4'h0) begin errs++; $display("FAIL reset_fsat got %b/%b want 0000", fs_b, fs_s); end
    checks++; if (y2_b !== 4'h0 || y2_o !== 4'h0) begin errs++; $display("FAIL reset_y2_w1 got %b/%b want 0000", y2_b, y2_o); end
    do_reset();
  endtask

  task automatic test_sweep();
    logic       ws[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0] es[7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd5, 3'd3, 3'd0};
    logic       zs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       ys[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    en = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      w = {3'b000, ws[k]};
      #1;
      checks++; if (y2_b[0] !== ys[k]) begin errs++; $display("FAIL sweep_y2 step %0d got %b want %b", k, y2_b[0], ys[k]); end
      tick();
      checks++; if (st_b[2:0] !== es[k]) begin errs++; $display("FAIL sweep_state step %0d got %0d want %0d", k, st_b[2:0], es[k]); end
      checks++; if (st_o[2:0] !== es[k]) begin errs++; $display("FAIL sweep_state_oh step %0d got %0d want %0d", k, st_o[2:0], es[k]); end
      checks++; if (z_b[0] !== zs[k]) begin errs++; $display("FAIL sweep_z step %0d got %b want %b", k, z_b[0], zs[k]); end
    end
    checks++; if (fc_b[7:0] !== 8'd1) begin errs++; $display("FAIL sweep_fcount got %0d want 1", fc_b[7:0]); end
    checks++; if (st_b[11:3] !== 9'd0) begin errs++; $display("FAIL sweep_other_lanes got %h want 0", st_b[11:3]); end
  endtask

  task automatic test_hold();
    do_reset();
    en = 4'b0010;
    w = 4'b0000;
    tick();
    tick();
    checks++; if (st_b[5:3] !== 3'd2) begin errs++; $display("FAIL hold_setup got %0d want 2", st_b[5:3]); end
    en = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      w = (k % 2 == 0) ? 4'b0010 : 4'b0000;
      #1;
      checks++; if (y2_b[1] !== w[1]) begin errs++; $display("FAIL hold_y2 step %0d got %b want %b", k, y2_b[1], w[1]); end
      tick();
      checks++; if (st_b[5:3] !== 3'd2 || st_o[5:3] !== 3'd2) begin errs++; $display("FAIL hold_state step %0d got %0d/%0d want 2", k, st_b[5:3], st_o[5:3]); end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] ec[4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    logic       es[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    en = 4'b0100;
    w = 4'b0000; tick();
    w = 4'b0100; tick();
    checks++; if (st_s[8:6] !== 3'd3) begin errs++; $display("FAIL sat_setup got %0d want 3", st_s[8:6]); end
    for (int k = 0; k < 4; k++) begin
      w = 4'b0000; tick();
      checks++; if (st_s[8:6] !== 3'd5) begin errs++; $display("FAIL sat_state step %0d got %0d want 5", k, st_s[8:6]); end
      checks++; if (fc_s[5:4] !== ec[k]) begin errs++; $display("FAIL sat_count step %0d got %0d want %0d", k, fc_s[5:4], ec[k]); end
      checks++; if (fs_s[2] !== es[k]) begin errs++; $display("FAIL sat_flag step %0d got %b want %b", k, fs_s[2], es[k]); end
      w = 4'b0100; tick();
    end
    checks++; if (fs_s[2] !== 1'b1 || fc_s[5:4] !== 2'd3) begin errs++; $display("FAIL sat_hold got %b/%0d want 1/3", fs_s[2], fc_s[5:4]); end
  endtask

  task automatic test_clr();
    do_reset();
    en = 4'b1000;
    w = 4'b0000; tick();
    w = 4'b1000; tick();
    w = 4'b0000; clr_cnt = 1'b1; tick();
    clr_cnt = 1'b0;
    checks++; if (st_b[11:9] !== 3'd5) begin errs++; $display("FAIL clr_state got %0d want 5", st_b[11:9]); end
    checks++; if (fc_b[31:24] !== 8'd0 || fc_o[31:24] !== 8'd0) begin errs++; $display("FAIL clr_count got %0d/%0d want 0", fc_b[31:24], fc_o[31:24]); end
    w = 4'b1000; tick();
    w = 4'b0000; tick();
    checks++; if (fc_b[31:24] !== 8'd1) begin errs++; $display("FAIL clr_next_entry got %0d want 1", fc_b[31:24]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 4'hF;
    w = 4'b0100; tick();
    w = 4'b0010; tick();
    w = 4'b0100; tick();
    checks++; if (st_b !== {3'd4, 3'd3, 3'd5, 3'd4}) begin errs++; $display("FAIL arst_setup got %h want %h", st_b, {3'd4, 3'd3, 3'd5, 3'd4}); end
    checks++; if (fc_b[15:8] !== 8'd1) begin errs++; $display("FAIL arst_setup_count got %0d want 1", fc_b[15:8]); end
    clr_cnt = 1'b1;
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (st_b !== 12'h0 || st_o !== 12'h0) begin errs++; $display("FAIL arst_state got %h/%h want 000", st_b, st_o); end
    checks++; if (z_b !== 4'h0 || z_o !== 4'h0) begin errs++; $display("FAIL arst_z got %b/%b want 0000", z_b, z_o); end
    checks++; if (fc_b !== 32'h0 || fc_o !== 32'h0) begin errs++; $display("FAIL arst_count got %h/%h want 0", fc_b, fc_o); end
    do_reset();
  endtask

  task automatic test_random_equiv();
    logic [2:0]  ms[4];
    logic [7:0]  mc[4];
    logic [2:0]  nx;
    logic [11:0] xs;
    logic [3:0]  xz, xy;
    logic [31:0] xc;
    do_reset();
    for (int i = 0; i < 4; i++) begin ms[i] = ST_A; mc[i] = 8'd0; end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      en = 4'($urandom);
      w = 4'($urandom);
      clr_cnt = ($urandom_range(0, 63) == 0);
      #1;
      for (int i = 0; i < 4; i++) begin nx = q6_next(ms[i], w[i]); xy[i] = nx[1]; end
      checks++; if (y2_b !== xy) begin errs++; $display("FAIL rnd_y2_bin cyc %0d got %b want %b", cyc, y2_b, xy); end
      checks++; if (y2_o !== xy) begin errs++; $display("FAIL rnd_y2_oh cyc %0d got %b want %b", cyc, y2_o, xy); end
      tick();
      for (int i = 0; i < 4; i++) begin
        if (en[i]) begin
          nx = q6_next(ms[i], w[i]);
          if (nx == ST_F && ms[i] != ST_F && mc[i] != 8'hFF) mc[i] = mc[i] + 8'd1;
          ms[i] = nx;
        end
        if (clr_cnt) mc[i] = 8'd0;
        xs[3*i +: 3] = ms[i];
        xz[i] = (ms[i] == ST_E) || (ms[i] == ST_F);
        xc[8*i +: 8] = mc[i];
      end
      checks++; if (st_b !== xs) begin errs++; $display("FAIL rnd_state_bin cyc %0d got %h want %h", cyc, st_b, xs); end
      checks++; if (st_o !== xs) begin errs++; $display("FAIL rnd_state_oh cyc %0d got %h want %h", cyc, st_o, xs); end
      checks++; if (z_b !== xz || z_o !== xz) begin errs++; $display("FAIL rnd_z cyc %0d got %b/%b want %b", cyc, z_b, z_o, xz); end
      checks++; if (fc_b !== xc || fc_o !== xc) begin errs++; $display("FAIL rnd_count cyc %0d got %h/%h want %h", cyc, fc_b, fc_o, xc); end
    end
    clr_cnt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_saturate();
    test_clr();
    test_async_reset();
    test_random_equiv();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
